// File: rtl/ctx_mchan.sv
// ctx_mchan: multi-channel context update engine.
//
// Holds NUM_CH independent DATA_W-bit context registers. Tagged ops
// {channel, opcode, operand} enter through a FIFO_DEPTH-entry input FIFO.
// Each popped op updates its channel's context. The updated value is
// presented on a registered output with valid/ready back-pressure.
//
// Ports:
//   clk       - clock, all logic on posedge
//   rst_n     - asynchronous active-low reset
//   in_val    - input op valid
//   in_rdy    - FIFO can accept (not full)
//   in_ch     - target channel of the input op
//   in_op     - opcode: 0 PASS, 1 ACC, 2 XOR, 3 CLR
//   in_data   - operand
//   out_val   - result valid
//   out_rdy   - consumer accepts result
//   out_ch    - channel of the result
//   out_data  - post-update context value
//   rd_ch     - debug read select
//   rd_data   - combinational ctx[rd_ch]
//   fifo_cnt  - current FIFO occupancy
//   ovf       - sticky overflow flag (push attempted while full)
module ctx_mchan #(
    parameter  int DATA_W     = 8,
    parameter  int NUM_CH     = 4,
    parameter  int FIFO_DEPTH = 4,
    localparam int CH_W       = $clog2(NUM_CH),
    localparam int PTR_W      = $clog2(FIFO_DEPTH),
    localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_val,
    output logic              in_rdy,
    input  logic [CH_W-1:0]   in_ch,
    input  logic [1:0]        in_op,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_val,
    input  logic              out_rdy,
    output logic [CH_W-1:0]   out_ch,
    output logic [DATA_W-1:0] out_data,
    input  logic [CH_W-1:0]   rd_ch,
    output logic [DATA_W-1:0] rd_data,
    output logic [CNT_W-1:0]  fifo_cnt,
    output logic              ovf
);

    typedef enum logic [1:0] {
        OP_PASS = 2'd0,
        OP_ACC  = 2'd1,
        OP_XOR  = 2'd2,
        OP_CLR  = 2'd3
    } op_e;

    // FIFO storage
    logic [CH_W-1:0]   fifo_ch [FIFO_DEPTH];
    op_e               fifo_op [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_d  [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    logic [DATA_W-1:0] ctx [NUM_CH];

    logic              push;
    logic              pop;
    logic              fifo_empty;
    logic [CH_W-1:0]   head_ch;
    op_e               head_op;
    logic [DATA_W-1:0] head_d;
    logic [DATA_W-1:0] head_ctx;
    logic [DATA_W-1:0] new_val;

    // Full/empty come from the registered count only, so a full FIFO
    // refuses a push even on a cycle where it also pops.
    assign in_rdy     = (fifo_cnt != CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (fifo_cnt == '0);
    assign push       = in_val && in_rdy;
    assign pop        = !fifo_empty && (!out_val || out_rdy);

    assign head_ch  = fifo_ch[rd_ptr];
    assign head_op  = fifo_op[rd_ptr];
    assign head_d   = fifo_d[rd_ptr];
    assign head_ctx = ctx[head_ch];

    assign rd_data  = ctx[rd_ch];

    always_comb begin
        new_val = '0;
        unique case (head_op)
            OP_PASS: new_val = head_d;
            OP_ACC:  new_val = head_ctx + head_d;  // carry dropped by width
            OP_XOR:  new_val = head_ctx ^ head_d;
            OP_CLR:  new_val = '0;
            default: new_val = '0;
        endcase
    end

    // Storage is not reset; occupancy and pointers alone define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_ch[wr_ptr] <= in_ch;
            fifo_op[wr_ptr] <= op_e'(in_op);
            fifo_d[wr_ptr]  <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_CH; i++) ctx[i] <= '0;
        end else if (pop) begin
            ctx[head_ch] <= new_val;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_val  <= 1'b0;
            out_ch   <= '0;
            out_data <= '0;
        end else if (pop) begin
            out_val  <= 1'b1;
            out_ch   <= head_ch;
            out_data <= new_val;
        end else if (out_val && out_rdy) begin
            out_val  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (in_val && !in_rdy) begin
            ovf <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ctx_mchan.sv
module tb_ctx_mchan;

    localparam int DATA_W = 8;
    localparam int NUM_CH = 4;
    localparam int DEPTH  = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_val;
    logic       in_rdy;
    logic [1:0] in_ch;
    logic [1:0] in_op;
    logic [7:0] in_data;
    logic       out_val;
    logic       out_rdy;
    logic [1:0] out_ch;
    logic [7:0] out_data;
    logic [1:0] rd_ch;
    logic [7:0] rd_data;
    logic [2:0] fifo_cnt;
    logic       ovf;

    ctx_mchan #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_val(in_val), .in_rdy(in_rdy), .in_ch(in_ch), .in_op(in_op),
        .in_data(in_data),
        .out_val(out_val), .out_rdy(out_rdy), .out_ch(out_ch),
        .out_data(out_data),
        .rd_ch(rd_ch), .rd_data(rd_data), .fifo_cnt(fifo_cnt), .ovf(ovf)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: op queue + context array + output register.
    typedef struct { int ch; int op; int d; } op_t;
    op_t q[$];
    int  m_ctx[NUM_CH];
    bit  m_oval;
    int  m_och;
    int  m_odata;
    bit  m_ovf;
    bit  rnd_rdy;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int apply_op(input int op, input int c, input int d);
        case (op)
            0: return d;
            1: return (c + d) % 256;
            2: return c ^ d;
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        q.delete();
        for (int i = 0; i < NUM_CH; i++) m_ctx[i] = 0;
        m_oval = 0; m_och = 0; m_odata = 0; m_ovf = 0;
    endtask

    // One clock: check combinational/pre-edge state, advance model, check post-edge.
    task automatic cycle(output bit accepted);
        bit  rdy, do_pop;
        op_t e;
        if (rnd_rdy) out_rdy = 1'($urandom_range(0, 1));
        rd_ch = 2'($urandom_range(0, NUM_CH - 1));
        #1;
        rdy = (q.size() != DEPTH);
        check("in_rdy", in_rdy, rdy);
        check("fifo_cnt_pre", fifo_cnt, q.size());
        check("rd_data", rd_data, m_ctx[rd_ch]);
        do_pop   = (q.size() > 0) && (!m_oval || out_rdy);
        accepted = in_val && rdy;
        if (in_val && !rdy) m_ovf = 1;
        if (do_pop) begin
            e = q.pop_front();
            m_ctx[e.ch] = apply_op(e.op, m_ctx[e.ch], e.d);
            m_oval  = 1;
            m_och   = e.ch;
            m_odata = m_ctx[e.ch];
        end else if (m_oval && out_rdy) begin
            m_oval = 0;
        end
        if (accepted) q.push_back('{ch: int'(in_ch), op: int'(in_op), d: int'(in_data)});
        @(posedge clk);
        #1;
        check("out_val", out_val, m_oval);
        check("out_ch", out_ch, m_och);
        check("out_data", out_data, m_odata);
        check("ovf", ovf, m_ovf);
        check("fifo_cnt", fifo_cnt, q.size());
    endtask

    // Present an op and hold it until accepted or maxwait cycles pass.
    task automatic send(input int ch, input int op, input int d, input int maxwait, input bit expect_acc);
        bit acc = 0;
        in_val = 1; in_ch = 2'(ch); in_op = 2'(op); in_data = 8'(d);
        for (int i = 0; i < maxwait && !acc; i++) cycle(acc);
        in_val = 0;
        if (expect_acc) check("send_accepted", acc, 1);
    endtask

    task automatic drain();
        bit acc;
        rnd_rdy = 0; out_rdy = 1; in_val = 0;
        for (int i = 0; i < 100 && (q.size() > 0 || m_oval); i++) cycle(acc);
        check("drain_out_val", out_val, 0);
        check("drain_fifo_cnt", fifo_cnt, 0);
    endtask

    task automatic peek(input int ch, input int exp);
        rd_ch = 2'(ch);
        #1;
        check("peek_rd_data", rd_data, exp);
    endtask

    task automatic do_reset();
        rst_n = 0;
        #1;
        model_reset();
        check("rst_out_val", out_val, 0);
        check("rst_fifo_cnt", fifo_cnt, 0);
        check("rst_ovf", ovf, 0);
        check("rst_in_rdy", in_rdy, 1);
        check("rst_out_ch", out_ch, 0);
        check("rst_out_data", out_data, 0);
        for (int i = 0; i < NUM_CH; i++) peek(i, 0);
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit acc;
        rst_n = 0; in_val = 0; in_ch = 0; in_op = 0; in_data = 0;
        out_rdy = 1; rd_ch = 0; rnd_rdy = 0;
        model_reset();
        #12;
        do_reset();

        // Single ACC on ch2
        out_rdy = 1;
        send(2, 1, 8'h05, 4, 1);
        cycle(acc);
        check("t1_out_val", out_val, 1);
        check("t1_out_ch", out_ch, 2);
        check("t1_out_data", out_data, 8'h05);
        peek(2, 8'h05);
        peek(0, 0);
        peek(1, 0);
        peek(3, 0);
        drain();

        // Back-to-back ch1: PASS, ACC (wrap), XOR, CLR
        send(1, 0, 8'hF0, 4, 1);
        send(1, 1, 8'h20, 4, 1);
        check("t2_first", out_data, 8'hF0);
        send(1, 2, 8'hFF, 4, 1);
        check("t2_wrap", out_data, 8'h10);
        send(1, 3, 8'hAA, 4, 1);
        check("t2_xor", out_data, 8'hEF);
        drain();
        check("t2_clr", out_data, 8'h00);
        peek(1, 0);

        // Back-pressure, fill, overflow
        out_rdy = 0;
        for (int i = 0; i < 5; i++) send(i % NUM_CH, 0, 8'h30 + i, 4, 1);
        check("t3_full_cnt", fifo_cnt, DEPTH);
        check("t3_in_rdy", in_rdy, 0);
        send(3, 0, 8'h99, 2, 0);
        check("t3_ovf", ovf, 1);
        out_rdy = 1;
        drain();
        check("t3_ovf_sticky", ovf, 1);

        // Full FIFO with out_rdy=1 and held input: refused on pop cycle, then taken
        out_rdy = 0;
        for (int i = 0; i < 5; i++) send(i % NUM_CH, 2, 8'h11 * (i + 1), 4, 1);
        out_rdy = 1;
        for (int i = 0; i < 4; i++) send(i, 1, 8'h01, 4, 1);
        drain();

        // Interleaved ACC 1, random back-pressure
        do_reset();
        rnd_rdy = 1;
        for (int r = 0; r < 64; r++)
            for (int c = 0; c < NUM_CH; c++) send(c, 1, 1, 50, 1);
        drain();
        for (int c = 0; c < NUM_CH; c++) peek(c, 8'h40);

        // Reset mid-stream with queued ops and a pending output
        out_rdy = 0;
        for (int i = 0; i < 4; i++) send(i, 0, 8'h55, 4, 1);
        check("t6_out_val_pre", out_val, 1);
        check("t6_cnt_pre", fifo_cnt, 3);
        do_reset();
        out_rdy = 1;
        send(0, 1, 8'h01, 4, 1);
        cycle(acc);
        check("t6_post_out_data", out_data, 8'h01);
        check("t6_post_out_ch", out_ch, 0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
